bcd_display_ctrl: RTL and testbench

Sequential binary-to-BCD controller that drives the eight-digit seven-segment decoder. It accepts an unsigned binary value with a start/busy/done handshake and converts it with a one-bit-per-cycle double-dabble engine. It then commits eight BCD digits plus a per-digit blank mask atomically, so the decoder never sees a partially converted number. It sits between datapath logic producing binary results and the seven-segment decoder's BCD7..BCD0/blank inputs.

---
 rtl/bcd_display_ctrl.sv | 140 ++++++++++++++
 tb/tb_bcd_display_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bcd_display_ctrl                                                 |
// | Purpose : sequential binary-to-BCD (double dabble) controller that commits |
// |           eight BCD digits and a blank mask atomically for a 7-seg decoder |
// | Option  : BCD_LZ_BLANK_EN enables leading-zero suppression on commit       |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+

module bcd_display_ctrl #(
   parameter int WIDTH = 26
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] value,
   output logic             busy,
   output logic             done,
   output logic [3:0]       BCD7,
   output logic [3:0]       BCD6,
   output logic [3:0]       BCD5,
   output logic [3:0]       BCD4,
   output logic [3:0]       BCD3,
   output logic [3:0]       BCD2,
   output logic [3:0]       BCD1,
   output logic [3:0]       BCD0,
   output logic [7:0]       blank
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_COMMIT  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_shift;
   logic [31:0]      r_acc;
   logic [31:0]      w_adj;
   logic [CW-1:0]    r_cnt;
   logic [31:0]      r_digits;
   logic [7:0]       r_blank;
   logic [7:0]       w_blank;
   logic             r_done;

   // add-3 correction on every nibble that would overflow past 9 when doubled
   generate
      for (genvar i = 0; i < 8; i++) begin : g_adj
         assign w_adj[4*i +: 4] = (r_acc[4*i +: 4] >= 4'd5) ? (r_acc[4*i +: 4] + 4'd3)
                                                             : r_acc[4*i +: 4];
      end
   endgenerate

`ifdef BCD_LZ_BLANK_EN
   logic [7:1] w_zero;

   generate
      for (genvar i = 1; i < 8; i++) begin : g_zero
         assign w_zero[i] = (r_acc[4*i +: 4] == 4'd0);
      end
      // a digit is dark only if it and every digit above it are zero
      for (genvar i = 1; i < 7; i++) begin : g_lz_chain
         assign w_blank[i] = w_blank[i+1] & w_zero[i];
      end
   endgenerate

   assign w_blank[7] = w_zero[7];
   assign w_blank[0] = 1'b0;
`else
   assign w_blank = 8'h00;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (start) w_next = S_CONVERT;
         S_CONVERT: if (r_cnt == CW'(1)) w_next = S_COMMIT;
         S_COMMIT:  w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_shift  <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_digits <= '0;
         r_blank  <= 8'hFF;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_shift <= value;
                  r_acc   <= '0;
                  r_cnt   <= CW'(WIDTH);
               end
            end
            S_CONVERT: begin
               {r_acc, r_shift} <= {w_adj, r_shift} << 1;
               r_cnt            <= r_cnt - CW'(1);
            end
            S_COMMIT: begin
               r_digits <= r_acc;
               r_blank  <= w_blank;
               r_done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy  = (r_state != S_IDLE);
   assign done  = r_done;
   assign blank = r_blank;
   assign BCD7  = r_digits[31:28];
   assign BCD6  = r_digits[27:24];
   assign BCD5  = r_digits[23:20];
   assign BCD4  = r_digits[19:16];
   assign BCD3  = r_digits[15:12];
   assign BCD2  = r_digits[11:8];
   assign BCD1  = r_digits[7:4];
   assign BCD0  = r_digits[3:0];

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_bcd_display_ctrl                                              |
// | Purpose : self-checking bench for bcd_display_ctrl (table, corner, random) |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+

module tb_bcd_display_ctrl;

   localparam int W = 26;

   logic          clock;
   logic          reset;
   logic          start;
   logic [W-1:0]  value;
   logic          busy;
   logic          done;
   logic [3:0]    BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0;
   logic [7:0]    blank;
   logic [31:0]   digits;

   int            n_vec = 0;
   int            n_err = 0;
   logic [31:0]   exp_d;
   logic [7:0]    exp_b;

   assign digits = {BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0};

   bcd_display_ctrl #(.WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .value (value),
      .busy  (busy),
      .done  (done),
      .BCD7  (BCD7),
      .BCD6  (BCD6),
      .BCD5  (BCD5),
      .BCD4  (BCD4),
      .BCD3  (BCD3),
      .BCD2  (BCD2),
      .BCD1  (BCD1),
      .BCD0  (BCD0),
      .blank (blank)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1);
   end

   typedef struct {
      logic [W-1:0] v;
      logic [31:0]  d;
      logic [7:0]   b_lz;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   // decimal digits straight from arithmetic on the number
   function automatic logic [31:0] model_d(input int unsigned v);
      logic [31:0] d;
      int unsigned p;
      p = 1;
      for (int i = 0; i < 8; i++) begin
         d[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return d;
   endfunction

   function automatic logic [7:0] model_b(input int unsigned v);
      logic [7:0] b;
      int unsigned p;
      b = 8'h00;
`ifdef BCD_LZ_BLANK_EN
      p = 10;
      for (int i = 1; i < 8; i++) begin
         if (v < p) b[i] = 1'b1;
         p = p * 10;
      end
`else
      p = 0;
      if (p != 0) b = 8'hFF;
`endif
      return b;
   endfunction

   task automatic convert(input logic [W-1:0] v, input logic [31:0] rd,
                          input logic [7:0] rb, input string nm);
      int   n;
      logic ok_busy;
      logic ok_hold;
      @(negedge clock);
      start = 1'b1;
      value = v;
      @(posedge clock);
      #1;
      start = 1'b0;
      value = ~v;
      n = 0;
      ok_busy = 1'b1;
      ok_hold = 1'b1;
      while (done !== 1'b1 && n < 60) begin
         if (busy !== 1'b1) ok_busy = 1'b0;
         if (digits !== exp_d || blank !== exp_b) ok_hold = 1'b0;
         @(posedge clock);
         #1;
         n++;
      end
      chk({nm, " latency"}, n, W + 1);
      chk({nm, " busy during"}, {31'd0, ok_busy}, 32'd1);
      chk({nm, " hold before commit"}, {31'd0, ok_hold}, 32'd1);
      exp_d = rd;
      exp_b = rb;
      chk({nm, " digits"}, digits, exp_d);
      chk({nm, " blank"}, {24'd0, blank}, {24'd0, exp_b});
      chk({nm, " busy in done cycle"}, {31'd0, busy}, 32'd0);
      @(posedge clock);
      #1;
      chk({nm, " done single pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int          n;
      int          ndone;
      int          at;
      logic        okb;
      logic        okh;
      int unsigned rv;
      logic [7:0]  bsel;

      tbl[0] = '{v: 26'd12345,    d: 32'h00012345, b_lz: 8'hE0};
      tbl[1] = '{v: 26'd67108863, d: 32'h67108863, b_lz: 8'h00};
      tbl[2] = '{v: 26'd0,        d: 32'h00000000, b_lz: 8'hFE};
      tbl[3] = '{v: 26'd1,        d: 32'h00000001, b_lz: 8'hFE};
      tbl[4] = '{v: 26'd10,       d: 32'h00000010, b_lz: 8'hFC};
      tbl[5] = '{v: 26'd10000000, d: 32'h10000000, b_lz: 8'h00};
      tbl[6] = '{v: 26'd9999999,  d: 32'h09999999, b_lz: 8'h80};

      reset = 1'b1;
      start = 1'b1;
      value = 26'd123;
      exp_d = 32'd0;
      exp_b = 8'hFF;
      repeat (3) @(negedge clock);
      chk("reset digits", digits, 32'd0);
      chk("reset blank", {24'd0, blank}, 32'h000000FF);
      chk("reset busy with start held", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      start = 1'b0;
      reset = 1'b0;

      for (int i = 0; i < 7; i++) begin
`ifdef BCD_LZ_BLANK_EN
         bsel = tbl[i].b_lz;
`else
         bsel = 8'h00;
`endif
         convert(tbl[i].v, tbl[i].d, bsel, $sformatf("table %0d", tbl[i].v));
      end

      // a second start during conversion must be dropped, not queued
      @(negedge clock);
      start = 1'b1;
      value = 26'd5;
      @(posedge clock);
      #1;
      start = 1'b0;
      value = 26'd0;
      ndone = 0;
      at = 0;
      okb = 1'b1;
      okh = 1'b1;
      for (int k = 0; k < 50; k++) begin
         if (k == 10) begin
            start = 1'b1;
            value = 26'd9;
         end
         if (k == 11) start = 1'b0;
         if (done === 1'b1) begin
            ndone++;
            if (at == 0) at = k;
         end
         if (k < W + 1 && busy !== 1'b1) okb = 1'b0;
         if (k < W + 1 && digits !== exp_d) okh = 1'b0;
         @(posedge clock);
         #1;
      end
      chk("ignore-start done count", ndone, 1);
      chk("ignore-start done cycle", at, W + 1);
      chk("ignore-start busy", {31'd0, okb}, 32'd1);
      chk("ignore-start hold", {31'd0, okh}, 32'd1);
      exp_d = model_d(5);
      exp_b = model_b(5);
      chk("ignore-start digits", digits, exp_d);

      // asynchronous reset in the middle of a conversion
      @(negedge clock);
      start = 1'b1;
      value = 26'd999;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (12) begin
         @(posedge clock);
         #1;
      end
      reset = 1'b1;
      #1;
      chk("midreset digits", digits, 32'd0);
      chk("midreset blank", {24'd0, blank}, 32'h000000FF);
      chk("midreset busy", {31'd0, busy}, 32'd0);
      chk("midreset done", {31'd0, done}, 32'd0);
      exp_d = 32'd0;
      exp_b = 8'hFF;
      @(negedge clock);
      reset = 1'b0;
      ndone = 0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (done === 1'b1) ndone++;
      end
      chk("midreset no done", ndone, 0);
      convert(26'd42, model_d(42), model_b(42), "after reset 42");

      // start held high through the done cycle launches the next conversion
      @(negedge clock);
      start = 1'b1;
      value = 26'd7;
      @(posedge clock);
      #1;
      value = 26'd8;
      n = 0;
      while (done !== 1'b1 && n < 60) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk("b2b first latency", n, W + 1);
      chk("b2b first digits", digits, model_d(7));
      @(posedge clock);
      #1;
      start = 1'b0;
      chk("b2b second accepted", {31'd0, busy}, 32'd1);
      n = 0;
      while (done !== 1'b1 && n < 60) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk("b2b second latency", n, W + 1);
      chk("b2b second digits", digits, model_d(8));
      exp_d = model_d(8);
      exp_b = model_b(8);

      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 3) == 0) rv = $urandom_range(0, 999);
         else rv = $urandom_range(0, 67108863);
         convert(W'(rv), model_d(rv), model_b(rv), $sformatf("random %0d", rv));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
